// File: rtl/weight_loader.sv
// weight_loader
//   Feeds the weight buffer write port from a DDR beat stream. A load command
//   gives a first buffer row (cmd_base_addr) and a row count (cmd_rows).
//   The block then accepts cmd_rows*GROUPS beats. Beat k lands in bank group
//   (k mod GROUPS), which is LANES adjacent banks, at row base + k/GROUPS.
//   After the last write, done pulses for one cycle.
//
//   Ports
//     clk, rst              rising-edge clock, async active-high reset
//     cmd_valid/cmd_ready   load command handshake
//     cmd_base_addr         first buffer row of the load
//     cmd_rows              row count (0 = no writes, done only)
//     ddr_data/valid/ready  DDR beat stream handshake
//     data_wr               beat data to the buffer (held when wr_en is 0)
//     wr_addr               buffer row address (wraps modulo 2^ADDR_LEN)
//     wr_en                 per-bank write enables, one LANES-wide group or 0
//     busy                  command in progress
//     done                  one-cycle pulse after the final write
//
//   Build option
//     WEIGHT_LOADER_SKID_EN  registered ddr_ready with a 2-entry skid FIFO in
//                            front of the write stage (+1 cycle write latency)
module weight_loader #(
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [ADDR_LEN-1:0]                   cmd_base_addr,
    input  logic [ADDR_LEN-1:0]                   cmd_rows,
    input  logic [DDR_DATA_LEN-1:0]               ddr_data,
    input  logic                                  ddr_valid,
    output logic                                  ddr_ready,
    output logic [DDR_DATA_LEN-1:0]               data_wr,
    output logic [ADDR_LEN-1:0]                   wr_addr,
    output logic [8*X_PE*X_MESH/DATA_LEN-1:0]     wr_en,
    output logic                                  busy,
    output logic                                  done
);

    localparam int BUFFER_NUM = 8 * X_PE * X_MESH / DATA_LEN;
    localparam int LANES      = DDR_DATA_LEN / DATA_LEN;
    localparam int GROUPS     = BUFFER_NUM / LANES;
    localparam int GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    // Holds cmd_rows*GROUPS without overflow.
    localparam int RW         = ADDR_LEN + GW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                    state_q;
    logic [ADDR_LEN-1:0]       base_q;
    logic [ADDR_LEN-1:0]       row_q;
    logic [GW-1:0]             grp_q;
    logic [RW-1:0]             rem_q;      // beats still to be accepted
    logic                      cmd_ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic [BUFFER_NUM-1:0]     wr_en_q;
    logic [ADDR_LEN-1:0]       wr_addr_q;
    logic [DDR_DATA_LEN-1:0]   data_wr_q;

    logic                      cmd_acc;
    logic                      beat_acc;
    logic [RW-1:0]             rem_d;
    logic                      write_fire;
    logic [DDR_DATA_LEN-1:0]   write_data;
    logic                      pipe_empty;
    logic [BUFFER_NUM-1:0]     wr_en_d;

    assign cmd_acc  = (state_q == IDLE) && cmd_ready_q && cmd_valid;
    assign beat_acc = ddr_valid && ddr_ready;
    assign rem_d    = rem_q - RW'(beat_acc);

`ifdef WEIGHT_LOADER_SKID_EN
    logic                      ddr_ready_q;
    logic [DDR_DATA_LEN-1:0]   fifo_q [2];
    logic                      fifo_wp_q;
    logic                      fifo_rp_q;
    logic [1:0]                fifo_cnt_q;
    logic [1:0]                fifo_cnt_d;

    assign ddr_ready  = ddr_ready_q;
    assign write_fire = (fifo_cnt_q != 2'd0);
    assign write_data = fifo_q[fifo_rp_q];
    assign pipe_empty = (fifo_cnt_q == 2'd0);
    assign fifo_cnt_d = fifo_cnt_q + 2'(beat_acc) - 2'(write_fire);

    // ddr_ready for the next cycle is decided from this cycle's acceptance,
    // so the flop drops as soon as the final beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= '0;
            ddr_ready_q <= 1'b0;
        end else begin
            if (beat_acc) begin
                fifo_q[fifo_wp_q] <= ddr_data;
                fifo_wp_q         <= ~fifo_wp_q;
            end
            if (write_fire) begin
                fifo_rp_q <= ~fifo_rp_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
            if (state_q == IDLE) begin
                ddr_ready_q <= cmd_acc && (cmd_rows != '0);
            end else if (state_q == LOAD) begin
                ddr_ready_q <= (rem_d != '0) && (fifo_cnt_d != 2'd2);
            end else begin
                ddr_ready_q <= 1'b0;
            end
        end
    end
`else
    assign ddr_ready  = (state_q == LOAD) && (rem_q != '0);
    assign write_fire = beat_acc;
    assign write_data = ddr_data;
    assign pipe_empty = 1'b1;
`endif

    // Enable the LANES banks of the current group.
    always_comb begin
        wr_en_d = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            if (grp_q == GW'(g)) begin
                wr_en_d[g*LANES +: LANES] = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            row_q       <= '0;
            grp_q       <= '0;
            rem_q       <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            data_wr_q   <= '0;
        end else begin
            done_q <= 1'b0;

            // Write stage: row/group counters track writes, not acceptances.
            if (write_fire) begin
                wr_en_q   <= wr_en_d;
                wr_addr_q <= base_q + row_q;
                data_wr_q <= write_data;
                if (grp_q == GW'(GROUPS - 1)) begin
                    grp_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    grp_q <= grp_q + 1'b1;
                end
            end else begin
                wr_en_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_acc) begin
                        base_q      <= cmd_base_addr;
                        row_q       <= '0;
                        grp_q       <= '0;
                        rem_q       <= RW'(cmd_rows) * RW'(GROUPS);
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_rows != '0) begin
                            state_q <= LOAD;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rem_q <= rem_d;
                    // All beats taken and the last one already on the write
                    // port: done lands in the cycle after that write.
                    if ((rem_q == '0) && pipe_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign data_wr   = data_wr_q;

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

    localparam int ADDR_LEN = 16;
    localparam int DDR_W    = 256;
    localparam int BN       = 32;
    localparam int GROUPS   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_base_addr;
    logic [15:0]       cmd_rows;
    logic [DDR_W-1:0]  ddr_data;
    logic              ddr_valid;
    logic              ddr_ready;
    logic [DDR_W-1:0]  data_wr;
    logic [15:0]       wr_addr;
    logic [BN-1:0]     wr_en;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    weight_loader #(
        .X_PE(16),
        .X_MESH(16),
        .ADDR_LEN(ADDR_LEN),
        .DATA_LEN(64),
        .DDR_DATA_LEN(DDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr),
        .cmd_rows(cmd_rows),
        .ddr_data(ddr_data),
        .ddr_valid(ddr_valid),
        .ddr_ready(ddr_ready),
        .data_wr(data_wr),
        .wr_addr(wr_addr),
        .wr_en(wr_en),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [15:0]      addr;
        logic [31:0]      en;
        logic [DDR_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] rows;
        int          mode;       // 0: ddr_valid held high, 1: toggled
        int          exp_writes;
    } vec_t;

    wr_t sbq[$];

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    int done_cyc = -10;
    int acc_cyc = -10;
    int n_acc = 0;
    int n_writes = 0;
    int n_done = 0;
    int n_cmd = 0;
    logic [15:0]      m_base = '0;
    logic [15:0]      m_row = '0;
    int               m_grp = 0;
    logic             exp_busy = 1'b0;
    logic [DDR_W-1:0] last_data = '0;

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_d(input string name, input logic [DDR_W-1:0] act, input logic [DDR_W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DDR_W-1:0] new_beat();
        logic [DDR_W-1:0] b;
        for (int i = 0; i < DDR_W / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    // Runs at the falling edge: checks outputs, then records handshakes that
    // complete at the coming rising edge.
    task automatic monitor();
        wr_t e;
        wr_t p;
        cyc++;
        if (wr_en !== '0) begin
            n_writes++;
            last_wr_cyc = cyc;
            if (sbq.size() == 0) begin
                chk_i("unexpected_write", int'(wr_en), 0);
                last_data = data_wr;
            end else begin
                e = sbq.pop_front();
                chk_i("wr_en", int'(wr_en), int'(e.en));
                chk_i("wr_addr", int'(wr_addr), int'(e.addr));
                chk_d("data_wr", data_wr, e.data);
                last_data = e.data;
            end
        end else begin
            chk_d("data_hold", data_wr, last_data);
        end
        chk_i("busy", int'(busy), int'(exp_busy));
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            exp_busy = 1'b0;
        end
        if (ddr_valid && ddr_ready) begin
            p.addr = m_base + m_row;
            p.en   = 32'hF << (m_grp * 4);
            p.data = ddr_data;
            sbq.push_back(p);
            n_acc++;
            m_grp++;
            if (m_grp == GROUPS) begin
                m_grp = 0;
                m_row = m_row + 16'd1;
            end
        end
        if (cmd_valid && cmd_ready) begin
            n_cmd++;
            acc_cyc  = cyc;
            m_base   = cmd_base_addr;
            m_row    = '0;
            m_grp    = 0;
            exp_busy = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [15:0] base, input logic [15:0] rows,
                            input int mode, input int exp_writes, input bit hold2);
        int w0 = n_writes;
        int a0 = n_acc;
        int d0 = n_done;
        int c0 = n_cmd;
        int k = 0;
        int budget = 0;
        int prev;
        cmd_base_addr = base;
        cmd_rows      = rows;
        cmd_valid     = 1'b1;
        ddr_valid     = 1'b0;
        ddr_data      = new_beat();
        while (n_cmd == c0 && budget < 50) begin tick(); budget++; end
        chk_i("cmd_accept", n_cmd - c0, 1);
        if (hold2) cmd_rows = '0;
        else cmd_valid = 1'b0;
        budget = 0;
        while (n_done == d0 && budget < 2000) begin
            ddr_valid = (mode == 0) || ((n_acc - a0) >= exp_writes) || (k % 2 == 0);
            k++;
            prev = n_acc;
            tick();
            budget++;
            if (n_acc != prev) ddr_data = new_beat();
        end
        chk_i("done_count", n_done - d0, 1);
        chk_i("beats_accepted", n_acc - a0, exp_writes);
        chk_i("writes", n_writes - w0, exp_writes);
        chk_i("scoreboard_empty", sbq.size(), 0);
        if (exp_writes > 0) chk_i("done_after_last_write", done_cyc - last_wr_cyc, 1);
        else chk_i("done_after_accept", done_cyc - acc_cyc, 1);
        if (!hold2) begin
            ddr_valid = 1'b1;   // surplus beat on the bus must not be taken
            tick();
            chk_i("cmd_ready_idle", int'(cmd_ready), 1);
            chk_i("surplus_not_accepted", n_acc - a0, exp_writes);
            ddr_valid = 1'b0;
        end else begin
            ddr_valid = 1'b0;
            budget = 0;
            while (n_cmd == c0 + 1 && budget < 50) begin tick(); budget++; end
            chk_i("held_cmd_accepted", n_cmd - c0, 2);
            chk_i("held_cmd_accept_gap", acc_cyc - done_cyc, 1);
            cmd_valid = 1'b0;
            budget = 0;
            while (n_done == d0 + 1 && budget < 50) begin tick(); budget++; end
            chk_i("zero_row_done", done_cyc - acc_cyc, 1);
            chk_i("zero_row_no_write", n_writes - w0, exp_writes);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int w0;
        int d0;
        int c0;
        int budget;
        int prev;

        vecs[0] = '{base: 16'h0010, rows: 16'd1, mode: 0, exp_writes: 8};
        vecs[1] = '{base: 16'h0100, rows: 16'd9, mode: 0, exp_writes: 72};
        vecs[2] = '{base: 16'hFFFF, rows: 16'd2, mode: 0, exp_writes: 16};
        vecs[3] = '{base: 16'h0040, rows: 16'd3, mode: 1, exp_writes: 24};
        vecs[4] = '{base: 16'h1234, rows: 16'd0, mode: 0, exp_writes: 0};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_base_addr = '0;
        cmd_rows = '0;
        ddr_data = '0;
        ddr_valid = 1'b0;
        #2;
        chk_i("reset_cmd_ready", int'(cmd_ready), 0);
        chk_i("reset_ddr_ready", int'(ddr_ready), 0);
        chk_i("reset_wr_en", int'(wr_en), 0);
        chk_i("reset_wr_addr", int'(wr_addr), 0);
        chk_d("reset_data_wr", data_wr, '0);
        chk_i("reset_busy", int'(busy), 0);
        chk_i("reset_done", int'(done), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_i("cmd_ready_after_reset", int'(cmd_ready), 1);

        foreach (vecs[i]) begin
            run_load(vecs[i].base, vecs[i].rows, vecs[i].mode, vecs[i].exp_writes, 1'b0);
        end

        // Second command held asserted through a load.
        run_load(16'h0200, 16'd1, 0, 8, 1'b1);
        tick();

        // Reset in the middle of a two-row load.
        w0 = n_writes;
        c0 = n_cmd;
        cmd_base_addr = 16'h0300;
        cmd_rows = 16'd2;
        cmd_valid = 1'b1;
        ddr_data = new_beat();
        budget = 0;
        while (n_cmd == c0 && budget < 50) begin tick(); budget++; end
        cmd_valid = 1'b0;
        ddr_valid = 1'b1;
        budget = 0;
        while ((n_writes - w0) < 5 && budget < 100) begin
            prev = n_acc;
            tick();
            budget++;
            if (n_acc != prev) ddr_data = new_beat();
        end
        chk_i("partial_writes_seen", (n_writes - w0) >= 5 ? 1 : 0, 1);
        d0 = n_done;
        rst = 1'b1;
        ddr_valid = 1'b0;
        #1;
        chk_i("midrst_wr_en", int'(wr_en), 0);
        chk_i("midrst_wr_addr", int'(wr_addr), 0);
        chk_d("midrst_data_wr", data_wr, '0);
        chk_i("midrst_busy", int'(busy), 0);
        chk_i("midrst_done", int'(done), 0);
        chk_i("midrst_ddr_ready", int'(ddr_ready), 0);
        chk_i("midrst_cmd_ready", int'(cmd_ready), 0);
        sbq.delete();
        exp_busy = 1'b0;
        last_data = '0;
        tick();
        tick();
        tick();
        chk_i("no_done_after_reset", n_done - d0, 0);
        rst = 1'b0;
        tick();
        run_load(16'h0400, 16'd1, 0, 8, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Upstream feeder for the weight buffer. It accepts a load command and a stream of DDR beats (DDR_DATA_LEN bits each), then drives the buffer's write port (`data_wr`, `wr_addr`, `wr_en`). Each beat lands in one group of DDR_DATA_LEN/DATA_LEN consecutive banks, and groups rotate across all BUFFER_NUM banks before the row address advances. A one-cycle `done` pulse tells the controller the buffer may be read (`rd_conf`).

## Interface
- X_PE, 16: PE columns.
- X_MESH, 16: mesh rows.
- ADDR_LEN, 16: buffer address width.
- DATA_LEN, 64: bank width in bits.
- DDR_DATA_LEN, 256: DDR beat width.
- BUFFER_NUM, 8*X_PE*X_MESH/DATA_LEN: bank count (32).
- LANES, DDR_DATA_LEN/DATA_LEN: banks per beat (4).
- GROUPS, BUFFER_NUM/LANES: beats per address row (8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_base_addr  in  ADDR_LEN  first buffer row.
- cmd_rows  in  ADDR_LEN  rows to write (total beats = cmd_rows*GROUPS).
- ddr_data  in  DDR_DATA_LEN  weight beat.
- ddr_valid  in  1  beat valid.
- ddr_ready  out  1  beat accepted when high with ddr_valid.
- data_wr  out  DDR_DATA_LEN  write data to buffer.
- wr_addr  out  ADDR_LEN  write row address.
- wr_en  out  BUFFER_NUM  per-bank write enables.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, LOAD and DONE.
- IDLE:
  - `cmd_ready`=1 and `ddr_ready`=0.
  - On `cmd_valid`: latch base and rows, and clear `grp` and `row`.
  - If `cmd_rows`≠0, go to LOAD. If `cmd_rows`=0, go to DONE (no writes issued).
- LOAD:
  - `cmd_ready`=0. Each accepted beat is written to banks `grp*LANES` .. `grp*LANES+LANES-1` at row `base+row`.
  - `grp` increments per beat. When it wraps from GROUPS-1 to 0, `row` increments.
  - After the beat with `row`=rows-1 and `grp`=GROUPS-1 is written, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state≠IDLE).
- `wr_addr` = base+row, modulo 2^ADDR_LEN; it wraps silently past the top of the buffer.
- `wr_en` is one-hot-group: exactly LANES adjacent bits are set, or all zero. It is all zero whenever no beat is written that cycle.
- `data_wr` holds its last value when `wr_en`=0.
- `ddr_ready` drops in time that no beat beyond the commanded count is ever accepted. Surplus beats stay on the bus for the next command.
- `ddr_valid` low during LOAD: no write that cycle, counters hold, no timeout.
- A `cmd_valid` during LOAD or DONE is not accepted; it is held off by `cmd_ready`=0.
- `rst` asserted at any time, including mid-load:
  - All outputs go to 0 immediately and state goes to IDLE.
  - The partial load is abandoned. Buffer contents already written are not restored.

## Timing
- Reset values: `cmd_ready`=0 while `rst` is high, then 1 in IDLE. `ddr_ready`=0, `data_wr`=0, `wr_addr`=0, `wr_en`=0, `busy`=0, `done`=0.
- Command accepted at edge E, so LOAD is active from the cycle after E. A zero-row command pulses `done` in the cycle after E.
- Write outputs are registered. A beat accepted in cycle t drives `wr_en`/`wr_addr`/`data_wr` in cycle t+1 (t+2 with skid; see Configuration).
- `done` is high in the cycle immediately after the final `wr_en` cycle. IDLE (`cmd_ready`=1) follows in the next cycle.
- Throughput is one beat per cycle with `ddr_valid` held high. A load takes `cmd_rows*GROUPS` beats.

## Configuration
- Macro `WEIGHT_LOADER_SKID_EN`.
- Defined:
  - `ddr_ready` comes directly from a flop.
  - A 2-entry skid FIFO sits between the DDR port and the write stage.
  - The accepted-beat counter is separate from the written-beat counter. `ddr_ready` is cleared one cycle early so that accepted beats never exceed the total.
  - Write latency is +1 cycle. `done` still follows the last write.
- Undefined:
  - `ddr_ready` = (state==LOAD && beats_remaining≠0), combinational.
  - No FIFO.

## Test plan
- Reset, then base=0x0010 and rows=1 with 8 back-to-back beats → `wr_en` sequence 0x0000000F, 0x000000F0 … 0xF0000000, all at `wr_addr`=0x0010. `done` follows one cycle after the last write.
- rows=9, base=0x0100, 72 beats → `wr_addr` steps 0x0100..0x0108, with 8 writes per row. `data_wr` matches each beat in order.
- Base=0xFFFF, rows=2 → first row written at 0xFFFF and second at 0x0000 (wrap).
- rows=3, with `ddr_valid` toggled 1,0,1,0… → 24 writes total, no write in invalid cycles, `done` after the 24th write. Extra beats after the 24th are not accepted (`ddr_ready`=0).
- `cmd_rows`=0 → no `wr_en`, `done` in the cycle after command accept. A second `cmd_valid` during LOAD is held off until IDLE.
- `rst` pulsed after the 5th beat of a rows=2 load → outputs zero in the same cycle, `busy`=0, no `done`. A new rows=1 command then completes normally.
